// File: rtl/lvds_pkg.sv
// Shared types and lane mappings for the 7:1 LVDS receive unpacker.
// Holds FSM encoding, pixel bundle and VESA/JEIDA decode helpers.
package lvds_pkg;

  localparam int LANE_W = 7;
  localparam int CAT_W  = 2 * LANE_W;

  localparam logic [LANE_W-1:0] CLK_PATTERN_DEF = 7'b1100011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       vs;
    logic       hs;
  } pixel_t;

  // d3[6] carries no payload in either mapping
  function automatic pixel_t decode_vesa(
    input logic [LANE_W-1:0] d0,
    input logic [LANE_W-1:0] d1,
    input logic [LANE_W-1:0] d2,
    input logic [LANE_W-1:0] d3
  );
    pixel_t p;
    p.r  = {d3[1:0], d0[5:0]};
    p.g  = {d3[3:2], d1[4:0], d0[6]};
    p.b  = {d3[5:4], d2[3:0], d1[6:5]};
    p.de = d2[6];
    p.vs = d2[5];
    p.hs = d2[4];
    return p;
  endfunction

  function automatic pixel_t decode_jeida(
    input logic [LANE_W-1:0] d0,
    input logic [LANE_W-1:0] d1,
    input logic [LANE_W-1:0] d2,
    input logic [LANE_W-1:0] d3
  );
    pixel_t p;
    p.r  = {d0[5:0], d3[1:0]};
    p.g  = {d1[4:0], d0[6], d3[3:2]};
    p.b  = {d2[3:0], d1[6:5], d3[5:4]};
    p.de = d2[6];
    p.vs = d2[5];
    p.hs = d2[4];
    return p;
  endfunction

endpackage

// File: rtl/lvds_word_align.sv
// One lane of the word aligner: two-deep word history and a
// shift-indexed 7-bit window over {prev, cur}.
module lvds_word_align
  import lvds_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [LANE_W-1:0] i_raw,
  input  logic [2:0]        i_shift,
  output logic [LANE_W-1:0] o_word
);

  logic [LANE_W-1:0] r_cur;
  logic [LANE_W-1:0] r_prev;
  logic [CAT_W-1:0]  w_cat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_cur  <= i_raw;
      r_prev <= r_cur;
    end
  end

  assign w_cat  = {r_prev, r_cur};
  assign o_word = w_cat[i_shift +: LANE_W];

endmodule

// File: rtl/lvds_to_lcd.sv
// 7:1 LVDS receive unpacker: finds the word boundary from the clock
// lane, aligns all lanes and decodes to 8-bit RGB plus DE/VS/HS.
module lvds_to_lcd
  import lvds_pkg::*;
#(
  parameter string             PROTOCOL    = "VESA",
  parameter logic [LANE_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int                LOCK_CNT    = 16,
  parameter int                ERR_CNT     = 4
) (
  input  logic              I_clk_1x,
  input  logic              I_rst_n,
  input  logic [LANE_W-1:0] I_lvds_clk,
  input  logic [LANE_W-1:0] I_lvds_d0,
  input  logic [LANE_W-1:0] I_lvds_d1,
  input  logic [LANE_W-1:0] I_lvds_d2,
  input  logic [LANE_W-1:0] I_lvds_d3,
  output logic [7:0]        O_R_data,
  output logic [7:0]        O_G_data,
  output logic [7:0]        O_B_data,
  output logic              O_DE,
  output logic              O_VS,
  output logic              O_HS,
  output logic              O_locked,
  output logic [2:0]        O_align_shift,
  output logic              O_lock_lost
);

  localparam bit        IS_JEIDA = (PROTOCOL == "JEIDA");
  localparam logic [7:0] LOCK_N  = 8'(LOCK_CNT);
  localparam logic [7:0] ERR_N   = 8'(ERR_CNT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_shift;
  logic [2:0] w_shift_nxt;
  logic [2:0] w_shift_inc;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic [7:0] r_err;
  logic [7:0] w_err_nxt;
  logic [7:0] w_err_inc;
  logic       w_lost_nxt;
  logic       w_match;
  logic       r_locked;
  logic       r_lost;
  pixel_t     w_pix;
  pixel_t     r_pix;

  logic [LANE_W-1:0] w_raw [5];
  logic [LANE_W-1:0] w_al  [5];

  assign w_raw[0] = I_lvds_clk;
  assign w_raw[1] = I_lvds_d0;
  assign w_raw[2] = I_lvds_d1;
  assign w_raw[3] = I_lvds_d2;
  assign w_raw[4] = I_lvds_d3;

  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    lvds_word_align u_align (
      .i_clk   (I_clk_1x),
      .i_rst_n (I_rst_n),
      .i_raw   (w_raw[gi]),
      .i_shift (r_shift),
      .o_word  (w_al[gi])
    );
  end

  assign w_match     = (w_al[0] == CLK_PATTERN);
  assign w_shift_inc = (r_shift == 3'd6) ? 3'd0 : r_shift + 3'd1;
  assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_err_inc   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_lost_nxt  = 1'b0;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_match) begin
          w_state_nxt = ST_VERIFY;
          w_cnt_nxt   = 8'd1;
        end else begin
          w_shift_nxt = w_shift_inc;
        end
      end
      ST_VERIFY: begin
        if (w_match) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= LOCK_N) begin
            w_state_nxt = ST_LOCKED;
            w_err_nxt   = 8'd0;
          end
        end else begin
          w_state_nxt = ST_SEARCH;
          w_shift_nxt = w_shift_inc;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (w_match) begin
          w_err_nxt = 8'd0;
        end else if (w_err_inc >= ERR_N) begin
          w_state_nxt = ST_SEARCH;
          w_shift_nxt = w_shift_inc;
          w_cnt_nxt   = 8'd0;
          w_err_nxt   = 8'd0;
          w_lost_nxt  = 1'b1;
        end else begin
          w_err_nxt = w_err_inc;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_shift_nxt = 3'd0;
        w_cnt_nxt   = 8'd0;
        w_err_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= ST_SEARCH;
      r_shift <= 3'd0;
      r_cnt   <= 8'd0;
      r_err   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // decode follows the state register, so it lags lock by one cycle
  always_comb begin
    if (IS_JEIDA)
      w_pix = decode_jeida(w_al[1], w_al[2], w_al[3], w_al[4]);
    else
      w_pix = decode_vesa(w_al[1], w_al[2], w_al[3], w_al[4]);
  end

  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pix    <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_pix    <= (r_state == ST_LOCKED) ? w_pix : '0;
      r_locked <= (r_state == ST_LOCKED);
      r_lost   <= w_lost_nxt;
    end
  end

  assign O_R_data      = r_pix.r;
  assign O_G_data      = r_pix.g;
  assign O_B_data      = r_pix.b;
  assign O_DE          = r_pix.de;
  assign O_VS          = r_pix.vs;
  assign O_HS          = r_pix.hs;
  assign O_locked      = r_locked;
  assign O_align_shift = r_shift;
  assign O_lock_lost   = r_lost;

endmodule

// File: tb/tb_lvds_to_lcd.sv
// Directed bench for lvds_to_lcd: VESA and JEIDA instances on a
// shared stimulus bus, checked against hand-packed pixel words.
module tb_lvds_to_lcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] lclk = '0;
  logic [6:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [6:0] d2 = '0;
  logic [6:0] d3 = '0;

  logic [7:0] v_r, v_g, v_b;
  logic       v_de, v_vs, v_hs, v_lk, v_ll;
  logic [2:0] v_sh;
  logic [7:0] j_r, j_g, j_b;
  logic       j_de, j_vs, j_hs, j_lk, j_ll;
  logic [2:0] j_sh;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] PAT = 7'b1100011;

  always #5 clk = ~clk;

  lvds_to_lcd #(.PROTOCOL("VESA")) u_vesa (
    .I_clk_1x(clk), .I_rst_n(rst_n),
    .I_lvds_clk(lclk),
    .I_lvds_d0(d0), .I_lvds_d1(d1),
    .I_lvds_d2(d2), .I_lvds_d3(d3),
    .O_R_data(v_r), .O_G_data(v_g), .O_B_data(v_b),
    .O_DE(v_de), .O_VS(v_vs), .O_HS(v_hs),
    .O_locked(v_lk), .O_align_shift(v_sh),
    .O_lock_lost(v_ll)
  );

  lvds_to_lcd #(.PROTOCOL("JEIDA")) u_jeida (
    .I_clk_1x(clk), .I_rst_n(rst_n),
    .I_lvds_clk(lclk),
    .I_lvds_d0(d0), .I_lvds_d1(d1),
    .I_lvds_d2(d2), .I_lvds_d3(d3),
    .O_R_data(j_r), .O_G_data(j_g), .O_B_data(j_b),
    .O_DE(j_de), .O_VS(j_vs), .O_HS(j_hs),
    .O_locked(j_lk), .O_align_shift(j_sh),
    .O_lock_lost(j_ll)
  );

  wire [26:0] v_pix = {v_r, v_g, v_b, v_de, v_vs, v_hs};
  wire [26:0] j_pix = {j_r, j_g, j_b, j_de, j_vs, j_hs};
  wire [31:0] v_all = {v_pix, v_lk, v_sh, v_ll};
  wire [31:0] j_all = {j_pix, j_lk, j_sh, j_ll};

  // VESA pixel A: R=A5 G=3C B=81 DE=1 VS=0 HS=1
  localparam logic [26:0] PIX_A = {8'hA5, 8'h3C, 8'h81, 3'b101};
  // VESA pixel B: R=FF G=00 B=00 DE=0 VS=1 HS=0
  localparam logic [26:0] PIX_B = {8'hFF, 8'h00, 8'h00, 3'b010};
  // JEIDA pixel: R=12 G=EF B=70 DE=1 VS=1 HS=0
  localparam logic [26:0] PIX_J = {8'h12, 8'hEF, 8'h70, 3'b110};

  function automatic logic [6:0] rot3(input logic [6:0] a);
    return {a[3:0], a[6:4]};
  endfunction

  task automatic set_words(input logic [6:0] c, input logic [6:0] a0,
                           input logic [6:0] a1, input logic [6:0] a2,
                           input logic [6:0] a3);
    lclk = c; d0 = a0; d1 = a1; d2 = a2; d3 = a3;
  endtask

  task automatic set_vesa_a();
    set_words(PAT, 7'h25, 7'h3E, 7'h50, 7'h22);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input bit jeida, input int max,
                           output int cyc);
    cyc = max + 1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((jeida ? j_lk : v_lk) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_words(7'($urandom), 7'($urandom), 7'($urandom),
                7'($urandom), 7'($urandom));
      @(negedge clk);
      checks++;
      if (v_all !== 32'h0 || j_all !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: vesa=%h jeida=%h want 0",
                 v_all, j_all);
      end
    end
    set_words(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if (v_sh !== 3'(i % 7) || v_lk !== 1'b0) begin
        errors++;
        $display("FAIL search_cycle[%0d]: shift=%0d lk=%b want %0d/0",
                 i, v_sh, v_lk, i % 7);
      end
    end
  endtask

  task automatic test_vesa();
    int cyc;
    set_vesa_a();
    do_reset();
    wait_lock(1'b0, 40, cyc);
    checks++;
    if (cyc > 25) begin
      errors++;
      $display("FAIL vesa_lock_time: cycles=%0d want <=25", cyc);
    end
    @(negedge clk);
    checks++;
    if (v_pix !== PIX_A || v_sh !== 3'd0) begin
      errors++;
      $display("FAIL vesa_pixel: got=%h sh=%0d want=%h sh=0",
               v_pix, v_sh, PIX_A);
    end
    set_words(PAT, 7'h3F, 7'h00, 7'h20, 7'h03);
    @(negedge clk);
    checks++;
    if (v_pix !== PIX_A) begin
      errors++;
      $display("FAIL latency_hold: got=%h want=%h", v_pix, PIX_A);
    end
    @(negedge clk);
    checks++;
    if (v_pix !== PIX_B) begin
      errors++;
      $display("FAIL latency_new: got=%h want=%h", v_pix, PIX_B);
    end
    set_vesa_a();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rotated();
    int cyc;
    set_words(rot3(PAT), rot3(7'h25), rot3(7'h3E),
              rot3(7'h50), rot3(7'h22));
    do_reset();
    wait_lock(1'b0, 40, cyc);
    @(negedge clk);
    checks++;
    if (cyc > 25 || v_sh !== 3'd3 || v_lk !== 1'b1) begin
      errors++;
      $display("FAIL rot3_lock: cyc=%0d sh=%0d lk=%b want <=25/3/1",
               cyc, v_sh, v_lk);
    end
    checks++;
    if (v_pix !== PIX_A) begin
      errors++;
      $display("FAIL rot3_pixel: got=%h want=%h", v_pix, PIX_A);
    end
  endtask

  task automatic test_jeida();
    int cyc;
    set_words(PAT, 7'h44, 7'h1D, 7'h67, 7'h4E);
    do_reset();
    wait_lock(1'b1, 40, cyc);
    @(negedge clk);
    checks++;
    if (cyc > 25 || j_pix !== PIX_J) begin
      errors++;
      $display("FAIL jeida_pixel: cyc=%0d got=%h want=%h",
               cyc, j_pix, PIX_J);
    end
    d3 = 7'h0E;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (j_pix !== PIX_J || j_lk !== 1'b1) begin
      errors++;
      $display("FAIL jeida_d3_6: got=%h lk=%b want=%h lk=1",
               j_pix, j_lk, PIX_J);
    end
  endtask

  task automatic test_err_tolerance();
    int cyc;
    int pulses;
    bit fell;
    bit zero_ok;
    set_vesa_a();
    do_reset();
    wait_lock(1'b0, 40, cyc);
    @(negedge clk);
    lclk = 7'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) lclk = PAT;
      checks++;
      if (v_lk !== 1'b1 || v_ll !== 1'b0 || v_pix !== PIX_A) begin
        errors++;
        $display("FAIL glitch3[%0d]: lk=%b ll=%b pix=%h want 1/0/%h",
                 i, v_lk, v_ll, v_pix, PIX_A);
      end
    end
    lclk = 7'h00;
    pulses = 0;
    fell = 1'b0;
    zero_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) lclk = PAT;
      if (v_ll === 1'b1) pulses++;
      if (v_lk === 1'b0 && !fell) begin
        fell = 1'b1;
        zero_ok = (v_pix === 27'h0);
      end
    end
    checks++;
    if (pulses != 1 || !fell) begin
      errors++;
      $display("FAIL lock_lost: pulses=%0d fell=%b want 1/1",
               pulses, fell);
    end
    checks++;
    if (!zero_ok) begin
      errors++;
      $display("FAIL unlocked_zero: pix=%h want 0", v_pix);
    end
    wait_lock(1'b0, 40, cyc);
    @(negedge clk);
    checks++;
    if (v_lk !== 1'b1 || v_sh !== 3'd0 || v_pix !== PIX_A) begin
      errors++;
      $display("FAIL relock: lk=%b sh=%0d pix=%h want 1/0/%h",
               v_lk, v_sh, v_pix, PIX_A);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (v_all !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got=%h want 0", v_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_lock(1'b0, 40, cyc);
    checks++;
    if (cyc > 25) begin
      errors++;
      $display("FAIL async_relock_time: cycles=%0d want <=25", cyc);
    end
    @(negedge clk);
    checks++;
    if (v_sh !== 3'd0 || v_pix !== PIX_A) begin
      errors++;
      $display("FAIL async_relock: sh=%0d pix=%h want 0/%h",
               v_sh, v_pix, PIX_A);
    end
  endtask

  initial begin
    test_reset();
    test_vesa();
    test_rotated();
    test_jeida();
    test_err_tolerance();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
